// File: rtl/maze_solver_wf.sv
// Wall-follower maze solver. A start request snapshots the maze and the hand
// rule, locates an opening on the bottom row (goal) and on the top row
// (entry), then walks the maze one move every three cycles with a right-
// or left-hand rule. The walk ends when the goal is reached, the move budget
// runs out, the walker is boxed in, or it comes back to its initial
// position and heading (it would only repeat itself from there).
module maze_solver_wf #(
    parameter int SIZE      = 9,
    parameter int N         = 4,
    parameter int MAX_STEPS = 1024,
    parameter int STEP_W    = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      hand,
    input  logic [SIZE-1:0][SIZE-1:0] maze,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic                      timeout,
    output logic [N-1:0]              x,
    output logic [N-1:0]              y,
    output logic [STEP_W-1:0]         steps,
    output logic [SIZE-1:0][SIZE-1:0] path
);

    typedef enum logic [2:0] {
        IDLE, FIND_STOP, FIND_START, VISIT, PICK, MOVE, DONE
    } state_t;

    // Clockwise order, so a right turn is +1 and a left turn is +3 (mod 4).
    typedef enum logic [1:0] {
        NORTH = 2'd0, EAST = 2'd1, SOUTH = 2'd2, WEST = 2'd3
    } heading_t;

    localparam logic [SIZE*SIZE-1:0] CELL_ONE = {{(SIZE*SIZE-1){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    heading_t                  heading_q, heading_d;
    logic [SIZE-1:0][SIZE-1:0] maze_q, maze_d;
    logic [SIZE-1:0][SIZE-1:0] path_q, path_d;
    logic                      hand_q, hand_d;
    logic [N-1:0]              gx_q, gx_d;
    logic [N-1:0]              sx_q, sx_d;
    logic [N-1:0]              x_q, x_d;
    logic [N-1:0]              y_q, y_d;
    logic [STEP_W-1:0]         steps_q, steps_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      found_q, found_d;
    logic                      timeout_q, timeout_d;
    heading_t                  firstDir, lastDir, backDir;

    // A cell outside the grid reads as a wall.
    function automatic logic cellOpen(input logic [SIZE-1:0][SIZE-1:0] m,
                                      input int cx, input int cy);
        logic [SIZE*SIZE-1:0] flat;
        if (cx < 0 || cx >= SIZE || cy < 0 || cy >= SIZE) return 1'b0;
        flat = m >> (cy * SIZE + cx);
        return ~flat[0];
    endfunction

    function automatic logic dirOpen(input logic [SIZE-1:0][SIZE-1:0] m,
                                     input logic [N-1:0] cx, input logic [N-1:0] cy,
                                     input heading_t d);
        int ix;
        int iy;
        ix = int'(cx);
        iy = int'(cy);
        case (d)
            NORTH:   iy = iy - 1;
            SOUTH:   iy = iy + 1;
            EAST:    ix = ix + 1;
            default: ix = ix - 1;
        endcase
        return cellOpen(m, ix, iy);
    endfunction

    function automatic heading_t turn(input heading_t h, input logic [1:0] amt);
        return heading_t'(h + amt);
    endfunction

    assign backDir  = turn(heading_q, 2'd2);
    assign firstDir = hand_q ? turn(heading_q, 2'd3) : turn(heading_q, 2'd1);
    assign lastDir  = hand_q ? turn(heading_q, 2'd1) : turn(heading_q, 2'd3);

    // State and datapath registers; reset clears everything, even mid-solve.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            heading_q <= SOUTH;
            maze_q    <= '0;
            path_q    <= '0;
            hand_q    <= 1'b0;
            gx_q      <= '0;
            sx_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            steps_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            heading_q <= heading_d;
            maze_q    <= maze_d;
            path_q    <= path_d;
            hand_q    <= hand_d;
            gx_q      <= gx_d;
            sx_q      <= sx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            steps_q   <= steps_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: opening scans, then the visit/pick/move walk cycle.
    always_comb begin
        state_d   = state_q;
        heading_d = heading_q;
        maze_d    = maze_q;
        path_d    = path_q;
        hand_d    = hand_q;
        gx_d      = gx_q;
        sx_d      = sx_q;
        x_d       = x_q;
        y_d       = y_q;
        steps_d   = steps_q;
        busy_d    = busy_q;
        done_d    = done_q;
        found_d   = found_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    maze_d    = maze;
                    hand_d    = hand;
                    path_d    = '0;
                    steps_d   = '0;
                    done_d    = 1'b0;
                    found_d   = 1'b0;
                    timeout_d = 1'b0;
                    x_d       = '0;
                    gx_d      = '0;
                    heading_d = SOUTH;
                    busy_d    = 1'b1;
                    state_d   = FIND_STOP;
                end
            end
            FIND_STOP: begin
                if (cellOpen(maze_q, int'(gx_q), SIZE - 1)) begin
                    state_d = FIND_START;
                end else if (gx_q == N'(SIZE - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    gx_d = gx_q + N'(1);
                end
            end
            FIND_START: begin
                if (cellOpen(maze_q, int'(x_q), 0)) begin
                    y_d     = '0;
                    sx_d    = x_q;
                    state_d = VISIT;
                end else if (x_q == N'(SIZE - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    x_d = x_q + N'(1);
                end
            end
            VISIT: begin
                path_d = path_q | (CELL_ONE << (int'(y_q) * SIZE + int'(x_q)));
                if (x_q == gx_q && y_q == N'(SIZE - 1)) begin
                    found_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = PICK;
                end
            end
            PICK: begin
                state_d = MOVE;
                if (steps_q == STEP_W'(MAX_STEPS)) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (dirOpen(maze_q, x_q, y_q, firstDir)) begin
                    heading_d = firstDir;
                end else if (dirOpen(maze_q, x_q, y_q, heading_q)) begin
                    heading_d = heading_q;
                end else if (dirOpen(maze_q, x_q, y_q, lastDir)) begin
                    heading_d = lastDir;
                end else if (dirOpen(maze_q, x_q, y_q, backDir)) begin
                    heading_d = backDir;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            MOVE: begin
                if (x_q == sx_q && y_q == '0 && heading_q == SOUTH && steps_q != '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    case (heading_q)
                        NORTH:   y_d = y_q - N'(1);
                        SOUTH:   y_d = y_q + N'(1);
                        EAST:    x_d = x_q + N'(1);
                        default: x_d = x_q - N'(1);
                    endcase
                    steps_d = steps_q + STEP_W'(1);
                    state_d = VISIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign found   = found_q;
    assign timeout = timeout_q;
    assign x       = x_q;
    assign y       = y_q;
    assign steps   = steps_q;
    assign path    = path_q;

endmodule

// File: tb/tb_maze_solver_wf.sv
// Bench for maze_solver_wf on a 5x5 grid: one instance with the normal move
// budget and one with a budget of 3. Stimulus pushes hand-computed results
// into per-instance queues; monitors pop and compare when done rises.
module tb_maze_solver_wf;

    typedef logic [4:0][4:0] grid_t;

    typedef struct {
        int    id;
        bit    found;
        bit    timeout;
        bit    checkPos;
        int    x;
        int    y;
        int    steps;
        grid_t path;
        int    lat;
        int    startEdge;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        startA, handA, startB, handB;
    grid_t       mazeA, mazeB;
    logic        busyA, doneA, foundA, timeoutA;
    logic        busyB, doneB, foundB, timeoutB;
    logic [2:0]  xA, yA, xB, yB;
    logic [10:0] stepsA;
    logic [3:0]  stepsB;
    grid_t       pathA, pathB;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   seenA    = 0;
    bit   seenB    = 0;
    exp_t qA[$];
    exp_t qB[$];

    maze_solver_wf #(.SIZE(5), .N(3), .MAX_STEPS(1024), .STEP_W(11)) dutA (
        .clk(clk), .rst(rstN), .start(startA), .hand(handA), .maze(mazeA),
        .busy(busyA), .done(doneA), .found(foundA), .timeout(timeoutA),
        .x(xA), .y(yA), .steps(stepsA), .path(pathA)
    );

    maze_solver_wf #(.SIZE(5), .N(3), .MAX_STEPS(3), .STEP_W(4)) dutB (
        .clk(clk), .rst(rstN), .start(startB), .hand(handB), .maze(mazeB),
        .busy(busyB), .done(doneB), .found(foundB), .timeout(timeoutB),
        .x(xB), .y(yB), .steps(stepsB), .path(pathB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic grid_t rows(input logic [4:0] r0, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [4:0] r3,
                                   input logic [4:0] r4);
        return {r4, r3, r2, r1, r0};
    endfunction

    function automatic exp_t mkExp(input int id, input bit f, input bit t, input bit cp,
                                   input int ex, input int ey, input int s,
                                   input grid_t p, input int lat);
        exp_t e;
        e.id = id; e.found = f; e.timeout = t; e.checkPos = cp;
        e.x = ex; e.y = ey; e.steps = s; e.path = p; e.lat = lat; e.startEdge = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic compareResult(input exp_t e, input logic f, input logic t,
                                 input int ax, input int ay, input int as, input grid_t ap);
        checkOutput($sformatf("s%0d_latency", e.id), cyc - e.startEdge, e.lat);
        checkOutput($sformatf("s%0d_found", e.id), int'(f), int'(e.found));
        checkOutput($sformatf("s%0d_timeout", e.id), int'(t), int'(e.timeout));
        checkOutput($sformatf("s%0d_steps", e.id), as, e.steps);
        checkOutput($sformatf("s%0d_path", e.id), int'(ap), int'(e.path));
        if (e.checkPos) begin
            checkOutput($sformatf("s%0d_x", e.id), ax, e.x);
            checkOutput($sformatf("s%0d_y", e.id), ay, e.y);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, int'(busyA), 0);
        checkOutput({tag, "_done"}, int'(doneA), 0);
        checkOutput({tag, "_found"}, int'(foundA), 0);
        checkOutput({tag, "_timeout"}, int'(timeoutA), 0);
        checkOutput({tag, "_x"}, int'(xA), 0);
        checkOutput({tag, "_y"}, int'(yA), 0);
        checkOutput({tag, "_steps"}, int'(stepsA), 0);
        checkOutput({tag, "_path"}, int'(pathA), 0);
        checkOutput({tag, "_busyB"}, int'(busyB), 0);
    endtask

    // Monitor for the full-budget instance.
    initial begin
        forever begin
            @(negedge clk);
            if (!doneA) begin
                seenA = 0;
            end else if (!seenA) begin
                seenA = 1;
                if (qA.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done_A: got done=1 with no result queued");
                end else begin
                    exp_t e;
                    e = qA.pop_front();
                    compareResult(e, foundA, timeoutA, int'(xA), int'(yA), int'(stepsA), pathA);
                end
            end
        end
    end

    // Monitor for the short-budget instance.
    initial begin
        forever begin
            @(negedge clk);
            if (!doneB) begin
                seenB = 0;
            end else if (!seenB) begin
                seenB = 1;
                if (qB.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done_B: got done=1 with no result queued");
                end else begin
                    exp_t e;
                    e = qB.pop_front();
                    compareResult(e, foundB, timeoutB, int'(xB), int'(yB), int'(stepsB), pathB);
                end
            end
        end
    end

    task automatic applyStimulus(input bit useB, input bit h, input grid_t m,
                                 input bit expectRes, input exp_t e);
        @(negedge clk);
        if (useB) begin
            startB = 1'b1; handB = h; mazeB = m;
        end else begin
            startA = 1'b1; handA = h; mazeA = m;
        end
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
        e.startEdge = cyc;
        checkOutput($sformatf("s%0d_busy_after_start", e.id),
                    int'(useB ? busyB : busyA), 1);
        if (expectRes) begin
            if (useB) qB.push_back(e);
            else      qA.push_back(e);
        end
    endtask

    task automatic waitDone(input bit useB, input int id);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = useB ? doneB : doneA;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL s%0d_wait_done: got no done within 300 cycles, expected done=1", id);
        end else begin
            repeat (2) @(negedge clk);
            checkOutput($sformatf("s%0d_done_held", id), int'(useB ? doneB : doneA), 1);
        end
    endtask

    initial begin
        grid_t corr, pocket, noStop, split, walls;
        grid_t pCol, pPocket, pLoop, pTime;

        corr    = rows(5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11011);
        pocket  = rows(5'b11011, 5'b11001, 5'b11011, 5'b11011, 5'b11011);
        noStop  = rows(5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11111);
        split   = rows(5'b11011, 5'b11011, 5'b11111, 5'b11011, 5'b11011);
        walls   = rows(5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111);
        pCol    = rows(5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100);
        pPocket = rows(5'b00100, 5'b00110, 5'b00100, 5'b00100, 5'b00100);
        pLoop   = rows(5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
        pTime   = rows(5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000);

        rstN = 1'b0;
        startA = 1'b0; handA = 1'b0; mazeA = walls;
        startB = 1'b0; handB = 1'b0; mazeB = walls;
        repeat (2) @(posedge clk);
        #1;
        checkReset("init");
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] corridor, right and left rule");
        applyStimulus(0, 0, corr, 1, mkExp(1, 1, 0, 1, 2, 4, 4, pCol, 19));
        waitDone(0, 1);
        applyStimulus(0, 1, corr, 1, mkExp(2, 1, 0, 1, 2, 4, 4, pCol, 19));
        waitDone(0, 2);

        $display("[TB] side pocket, right and left rule");
        applyStimulus(0, 0, pocket, 1, mkExp(3, 1, 0, 1, 2, 4, 6, pPocket, 25));
        waitDone(0, 3);
        applyStimulus(0, 1, pocket, 1, mkExp(4, 1, 0, 1, 2, 4, 4, pCol, 19));
        waitDone(0, 4);

        $display("[TB] no opening on bottom row");
        applyStimulus(0, 0, noStop, 1, mkExp(5, 0, 0, 0, 0, 0, 0, '0, 5));
        waitDone(0, 5);

        $display("[TB] unreachable goal, loop detection");
        applyStimulus(0, 0, split, 1, mkExp(6, 0, 0, 1, 2, 0, 2, pLoop, 15));
        waitDone(0, 6);

        $display("[TB] move budget of 3");
        applyStimulus(1, 0, corr, 1, mkExp(7, 0, 1, 1, 2, 3, 3, pTime, 17));
        waitDone(1, 7);

        $display("[TB] reset mid-solve");
        applyStimulus(0, 0, corr, 0, mkExp(8, 0, 0, 0, 0, 0, 0, '0, 0));
        repeat (8) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checkReset("midsolve");
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] restart with start pulse and maze change while busy");
        applyStimulus(0, 0, corr, 1, mkExp(9, 1, 0, 1, 2, 4, 4, pCol, 19));
        repeat (3) @(negedge clk);
        startA = 1'b1; handA = 1'b1; mazeA = pocket;
        @(negedge clk);
        startA = 1'b0; mazeA = walls;
        waitDone(0, 9);

        checkOutput("queueA_drained", qA.size(), 0);
        checkOutput("queueB_drained", qB.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
